// File: rtl/fp16_to_fp8_packer.sv
// Collects FP16 words from a byte stream (low byte first) and emits them as FP8 E4M3 (bias 7)
// with overflow/underflow/inexact flags through a single-entry valid/ready output register.
module fp16_to_fp8_packer #(
    parameter bit SATURATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [2:0] out_flags
);

    typedef enum logic {StLow, StHigh} phase_e;

    phase_e      phase_q, phase_d;
    logic [7:0]  low_q, low_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [2:0]  out_flags_q, out_flags_d;
    logic        accept;
    logic        load;
    logic [10:0] conv;

    // Returns {ovf, unf, inexact, fp8}.
    function automatic logic [10:0] fp16_to_fp8(input logic [15:0] h);
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        logic [2:0] m3;
        logic       g;
        logic       st;
        logic       rnd;
        logic [3:0] sum;
        logic [5:0] ee;
        logic [10:0] sig;
        logic [10:0] gbit;
        logic [4:0] sh;
        logic [6:0] sat_code;
        logic       ovf;
        logic       unf;
        logic       inx;
        logic [7:0] d;
        s        = h[15];
        e        = h[14:10];
        m        = h[9:0];
        sat_code = SATURATE ? 7'h7E : 7'h7F;
        ovf      = 1'b0;
        unf      = 1'b0;
        inx      = 1'b0;
        d        = {s, 7'h00};
        m3       = 3'd0;
        g        = 1'b0;
        st       = 1'b0;
        rnd      = 1'b0;
        sum      = 4'd0;
        ee       = 6'd0;
        sig      = {1'b1, m};
        gbit     = 11'd0;
        sh       = 5'd0;
        if (e == 5'd0) begin
            unf = |m;
            inx = |m;
        end else if (e == 5'd31) begin
            if (m != 10'd0) begin
                d = {s, 7'h7F};
            end else begin
                d   = {s, sat_code};
                ovf = 1'b1;
            end
        end else if (e >= 5'd9) begin
            m3  = m[9:7];
            g   = m[6];
            st  = |m[5:0];
            rnd = g & (st | m3[0]);
            sum = {1'b0, m3} + {3'b000, rnd};
            ee  = {1'b0, e} - 6'd8 + {5'b00000, sum[3]};
            inx = g | st;
            if (ee > 6'd15 || (ee == 6'd15 && sum[2:0] == 3'd7)) begin
                d   = {s, sat_code};
                ovf = 1'b1;
                inx = 1'b1;
            end else begin
                d = {s, ee[3:0], sum[2:0]};
            end
        end else begin
            // Subnormal: count of 2^-9 units is {1,M} >> (16-E); a carry to 8 lands on min normal.
            sh   = 5'd16 - e;
            m3   = 3'(sig >> sh);
            gbit = 11'd1 << (sh - 5'd1);
            g    = |(sig & gbit);
            st   = |(sig & (gbit - 11'd1));
            rnd  = g & (st | m3[0]);
            sum  = {1'b0, m3} + {3'b000, rnd};
            d    = {s, 3'b000, sum};
            unf  = ~sum[3];
            inx  = g | st;
        end
        return {ovf, unf, inx, d};
    endfunction

    assign conv = fp16_to_fp8({in_byte, low_q});

    always_comb begin
        phase_d  = phase_q;
        low_d    = low_q;
        load     = 1'b0;
        in_ready = sync || (phase_q == StLow) || !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        if (sync) begin
            // A byte arriving with sync starts the new frame.
            phase_d = accept ? StHigh : StLow;
            if (accept) begin
                low_d = in_byte;
            end
        end else if (accept) begin
            unique case (phase_q)
                StLow: begin
                    low_d   = in_byte;
                    phase_d = StHigh;
                end
                StHigh: begin
                    load    = 1'b1;
                    phase_d = StLow;
                end
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = conv[7:0];
            out_flags_d = conv[10:8];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= StLow;
            low_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_flags_q <= 3'b000;
        end else begin
            phase_q     <= phase_d;
            low_q       <= low_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp16_to_fp8_packer.sv
// Bench for fp16_to_fp8_packer: saturating and NaN-on-overflow instances driven in parallel,
// checked against a nearest-value search model and hand-computed literals.
module tb_fp16_to_fp8_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_ready;
    logic       in_ready_s, in_ready_n;
    logic       out_valid_s, out_valid_n;
    logic [7:0] out_data_s, out_data_n;
    logic [2:0] out_flags_s, out_flags_n;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic        model_high;
    logic [7:0]  model_low;

    always #5 clk = ~clk;

    fp16_to_fp8_packer #(.SATURATE(1'b1)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready_s),
        .out_valid (out_valid_s),
        .out_data  (out_data_s),
        .out_ready (out_ready),
        .out_flags (out_flags_s)
    );

    fp16_to_fp8_packer #(.SATURATE(1'b0)) dut_nan (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready_n),
        .out_valid (out_valid_n),
        .out_data  (out_data_n),
        .out_ready (out_ready),
        .out_flags (out_flags_n)
    );

    // Picks the nearest E4M3 code by exhaustive search over exact scaled values (units of 2^-24),
    // ties to the even code; code 0x7F stands in for 480 so anything rounding there overflows.
    function automatic logic [10:0] model(input logic [15:0] h, input bit sat);
        logic       s;
        int         e;
        int         m;
        longint     v;
        longint     cv;
        longint     d;
        longint     bd;
        int         best;
        logic [6:0] satc;
        logic       unf;
        logic       inx;
        s    = h[15];
        e    = int'(h[14:10]);
        m    = int'(h[9:0]);
        satc = sat ? 7'h7E : 7'h7F;
        if (e == 31) return (m != 0) ? {3'b000, s, 7'h7F} : {3'b100, s, satc};
        v    = (e == 0) ? longint'(m) : (longint'(1024 + m) <<< (e - 1));
        best = 0;
        bd   = -1;
        for (int c = 0; c < 128; c++) begin
            cv = (c < 8) ? (longint'(c) <<< 15) : (longint'(8 + c % 8) <<< (c / 8 + 14));
            d  = (v > cv) ? v - cv : cv - v;
            if (bd < 0 || d < bd || (d == bd && c % 2 == 0)) begin
                bd   = d;
                best = c;
            end
        end
        if (best == 127) return {3'b101, s, satc};
        unf = (v != 0) && (best < 8);
        inx = (bd != 0);
        return {1'b0, unf, inx, s, 7'(best)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: tracks the byte phase and the queue of words whose results are owed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_high <= 1'b0;
            model_low  <= 8'h00;
        end else begin
            if (exp_q.size() != 0 && out_ready) exp_q.pop_front();
            if (sync) begin
                model_high <= in_valid;
                if (in_valid) model_low <= in_byte;
            end else if (in_valid && (!model_high || exp_q.size() == 0 || out_ready)) begin
                if (!model_high) begin
                    model_low  <= in_byte;
                    model_high <= 1'b1;
                end else begin
                    exp_q.push_back({in_byte, model_low});
                    model_high <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_sat", {4'h0, in_ready_s, out_valid_s, out_flags_s, out_data_s},
                  {4'h0, 1'b1, 1'b0, 3'b000, 8'h00});
            check("reset_nan", {4'h0, in_ready_n, out_valid_n, out_flags_n, out_data_n},
                  {4'h0, 1'b1, 1'b0, 3'b000, 8'h00});
        end else begin
            check("in_ready", {14'h0, in_ready_s, in_ready_n},
                  {14'h0, {2{sync || !model_high || exp_q.size() == 0 || out_ready}}});
            check("out_valid", {14'h0, out_valid_s, out_valid_n},
                  {14'h0, {2{exp_q.size() != 0}}});
            if (exp_q.size() != 0) begin
                check("result_sat", {5'h0, out_flags_s, out_data_s}, {5'h0, model(exp_q[0], 1'b1)});
                check("result_nan", {5'h0, out_flags_n, out_data_n}, {5'h0, model(exp_q[0], 1'b0)});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  w;
        bit  done;
        w    = 0;
        done = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_byte  = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready_s) begin
                done = 1'b1;
            end else begin
                w++;
                if (w > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL send_timeout: in_ready stuck 0, byte %h", b);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic pair(input logic [15:0] h);
        send_byte(h[7:0]);
        send_byte(h[15:8]);
    endtask

    // Result must be visible on the cycle right after the high byte is taken.
    task automatic lit(input string name, input logic [15:0] h,
                       input logic [10:0] exp_s, input logic [10:0] exp_n, input bit ovf_only);
        pair(h);
        @(negedge clk);
        if (ovf_only) begin
            check({name, "_sat"}, {6'h0, out_valid_s, out_flags_s[2], out_data_s},
                  {6'h0, 1'b1, exp_s[10], exp_s[7:0]});
            check({name, "_nan"}, {6'h0, out_valid_n, out_flags_n[2], out_data_n},
                  {6'h0, 1'b1, exp_n[10], exp_n[7:0]});
        end else begin
            check({name, "_sat"}, {4'h0, out_valid_s, out_flags_s, out_data_s}, {4'h0, 1'b1, exp_s});
            check({name, "_nan"}, {4'h0, out_valid_n, out_flags_n, out_data_n}, {4'h0, 1'b1, exp_n});
        end
    endtask

    logic [15:0] edge_words [16] = '{
        16'h0000, 16'h8000, 16'hFC00, 16'h7E01, 16'hFE00, 16'h5F00, 16'h5F40, 16'h5F41,
        16'h5F80, 16'h2400, 16'h23FF, 16'h2380, 16'h2000, 16'h0400, 16'hBC00, 16'h4B80
    };

    initial begin
        rst_n     = 1'b0;
        sync      = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;

        check("model_one",    {5'h0, model(16'h3C00, 1'b1)}, {5'h0, 3'b000, 8'h38});
        check("model_tie",    {5'h0, model(16'h3C40, 1'b1)}, {5'h0, 3'b001, 8'h38});
        check("model_max",    {5'h0, model(16'h7BFF, 1'b0)}, {5'h0, 3'b101, 8'h7F});
        check("model_sub",    {5'h0, model(16'h1800, 1'b1)}, {5'h0, 3'b010, 8'h01});
        check("model_negsub", {5'h0, model(16'h8001, 1'b1)}, {5'h0, 3'b011, 8'h80});

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        lit("one",      16'h3C00, {3'b000, 8'h38}, {3'b000, 8'h38}, 1'b0);
        lit("neg2p5",   16'hC100, {3'b000, 8'hC2}, {3'b000, 8'hC2}, 1'b0);
        lit("tie_even", 16'h3C40, {3'b001, 8'h38}, {3'b001, 8'h38}, 1'b0);
        lit("round_up", 16'h3CC0, {3'b001, 8'h3A}, {3'b001, 8'h3A}, 1'b0);
        lit("max_fp16", 16'h7BFF, {3'b101, 8'h7E}, {3'b101, 8'h7F}, 1'b0);
        lit("inf",      16'h7C00, {3'b100, 8'h7E}, {3'b100, 8'h7F}, 1'b1);
        lit("p2m10",    16'h1400, {3'b011, 8'h00}, {3'b011, 8'h00}, 1'b0);
        lit("p2m9",     16'h1800, {3'b010, 8'h01}, {3'b010, 8'h01}, 1'b0);
        lit("neg_sub",  16'h8001, {3'b011, 8'h80}, {3'b011, 8'h80}, 1'b0);

        foreach (edge_words[i]) pair(edge_words[i]);
        for (int i = 0; i < 24; i++) pair(16'($urandom));
        repeat (3) @(posedge clk);

        // Backpressure: second word stalls in HIGH while the first result is held.
        #2;
        out_ready = 1'b0;
        pair(16'h3C00);
        send_byte(8'h00);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_byte  = 8'hC1;
        repeat (4) begin
            @(negedge clk);
            check("stall_ready", {15'h0, in_ready_s}, 16'h0000);
            check("stall_hold", {7'h0, out_valid_s, out_data_s}, {7'h0, 1'b1, 8'h38});
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_second", {7'h0, out_valid_s, out_data_s}, {7'h0, 1'b1, 8'hC2});
        repeat (3) @(posedge clk);

        // Reset mid-frame drops the captured low byte.
        send_byte(8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        lit("after_rst", 16'h3C00, {3'b000, 8'h38}, {3'b000, 8'h38}, 1'b0);

        send_byte(8'h00);
        @(posedge clk);
        #2;
        sync = 1'b1;
        @(posedge clk);
        #2;
        sync = 1'b0;
        lit("after_sync", 16'h3C00, {3'b000, 8'h38}, {3'b000, 8'h38}, 1'b0);

        // A byte presented with sync becomes the new low byte.
        send_byte(8'h77);
        @(posedge clk);
        #2;
        sync     = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h00;
        @(posedge clk);
        #2;
        sync     = 1'b0;
        in_valid = 1'b0;
        send_byte(8'h3C);
        @(negedge clk);
        check("sync_low", {7'h0, out_valid_s, out_data_s}, {7'h0, 1'b1, 8'h38});

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
